pcm_playback: RTL and testbench
===============================

# pcm_playback

Playback stage for the voice path. It reads the packed 8-bit sample words that the recorder wrote into the voice RAM, unpacks four samples per word, and replays them at the recording sample rate as a PWM audio stream with amplifier enable. It owns the RAM read port: addresses `0..CHUNKS-1`, one synchronous read per word, with a prefetch so sample timing has no gaps.

## Interface
Parameters:
- `SAMPLE_W`, 8, bits per sample; RAM word is `4*SAMPLE_W`.
- `ADDR_W`, 12, RAM address width.
- `CHUNKS`, 2830, number of words played; legal range `1 <= CHUNKS <= 2**ADDR_W`.
- `CLKS_PER_SAMPLE`, 300, clk cycles each sample is held (2.4 MHz / 8 kHz); must be at least 4.

Ports:
- `clk`, in, 1, clock.
- `rst`, in, 1, reset; asynchronous, active-high.
- `play`, in, 1, start request, sampled in IDLE.
- `stop`, in, 1, abort request; wins over everything except `rst`.
- `ram_rd_en`, out, 1, read strobe.
- `ram_rd_addr`, out, `ADDR_W`, read address.
- `ram_rd_data`, in, `4*SAMPLE_W`, read data; valid the cycle after `ram_rd_en` is sampled high.
- `busy`, out, 1, high while playing.
- `done`, out, 1, one-cycle pulse on natural completion.
- `audio_pwm`, out, 1, PWM audio.
- `audio_sd`, out, 1, amplifier enable; equals `busy`.

## Operation
- States are IDLE, PRIME, LOAD, PLAY and DONE.
- IDLE:
  - `play & ~stop` goes to PRIME.
  - `play` while not in IDLE is ignored.
- PRIME: `ram_rd_en=1`, `ram_rd_addr=0`. Always goes to LOAD.
- LOAD: capture `ram_rd_data` into `cur_word`. Clear `word_idx`, `lane` and `tick`. Go to PLAY.
- PLAY, sample register:
  - `sample = cur_word[lane*SAMPLE_W +: SAMPLE_W]`.
  - Lane 0 (the LSB byte) plays first, lane 3 last.
  - `tick` counts `0..CLKS_PER_SAMPLE-1`.
  - At the terminal tick, `lane` increments (mod 4).
- PLAY, prefetch:
  - In the cycle with `lane==0 && tick==0`, if `word_idx < CHUNKS-1`, assert `ram_rd_en` with `ram_rd_addr = word_idx+1`.
  - Capture `ram_rd_data` into `nxt_word` on the following edge.
  - No read is ever issued at or beyond address `CHUNKS`.
- PLAY, end of lane 3 at the terminal tick:
  - If `word_idx == CHUNKS-1`, go to DONE.
  - Otherwise `cur_word <= nxt_word`, `word_idx++`, `lane <= 0`, `tick <= 0`, and stay in PLAY.
- DONE: `done=1` for exactly one cycle, then IDLE.
- `stop` in PRIME, LOAD, PLAY or DONE returns to IDLE next cycle. `done` is not pulsed; `stop` in the DONE cycle still allows that cycle's `done` pulse.
  - Counters are cleared.
  - The next `play` restarts from address 0.
- `stop` together with the final terminal tick: `stop` wins, giving IDLE with no `done`.
- PWM:
  - `pwm_cnt` is a free-running `SAMPLE_W`-bit counter from reset and wraps at `2**SAMPLE_W`.
  - `audio_pwm` is registered: `busy_state && (pwm_cnt < sample)`.
  - Sample `0x00` gives a constant low output; sample `0xFF` gives 255/256 duty.
- Outside PLAY, `sample` is held at midscale `2**(SAMPLE_W-1)` (0x80).

## Timing
- Reset values:
  - State IDLE.
  - `ram_rd_en=0`, `ram_rd_addr=0`.
  - `busy=0`, `done=0`.
  - `audio_pwm=0`, `audio_sd=0`.
  - `pwm_cnt=0`, `sample=0x80`.
  - `cur_word`, `nxt_word`, `word_idx`, `lane`, `tick` all 0.
- `rst` mid-playback returns to these values immediately (asynchronous). No `done` is pulsed.
- Outputs:
  - `ram_rd_en` and `ram_rd_addr` are combinational from state and counters.
  - `busy`, `done` and `audio_sd` are decoded from state.
  - `audio_pwm` lags `sample` by one cycle.
- Latency, with `play` sampled at edge 0:
  - PRIME in cycle 1.
  - LOAD in cycle 2.
  - First PLAY cycle is cycle 3.
  - `busy` is high in PRIME, LOAD, PLAY and DONE.
- Each sample is held exactly `CLKS_PER_SAMPLE` cycles with no gap between words.
- The DONE cycle is `3 + 4*CHUNKS*CLKS_PER_SAMPLE`.
- Prefetch data arrives `4*CLKS_PER_SAMPLE - 2` cycles before it is needed.

## Test plan
- **Reset:** assert `rst` mid-PLAY.
  - Required: all outputs reset asynchronously, `sample=0x80`, no `done`.
  - Then `play` restarts at `ram_rd_addr=0`.
- **Normal playback:** `CHUNKS=3`, `CLKS_PER_SAMPLE=4`; RAM words `0x04030201`, `0x08070605`, `0x0C0B0A09`; `play` at edge 0.
  - Required: `sample` sequence `01..0C`, each value held 4 cycles starting at cycle 3.
  - Reads: addr 0 at cycle 1, addr 1 at cycle 3, addr 2 at cycle 19. Each address is read once; address 3 is never read.
  - `done` pulses at cycle 51, then `busy=0`.
- **PWM duty:** `CLKS_PER_SAMPLE=1024`, all samples `0x40`.
  - Required: `audio_pwm` high for 64 of every 256 cycles; with `0x00`, never high.
- **Stop mid-word:** `stop` during lane 2 of word 1.
  - Required: IDLE next cycle, `busy=0`, `audio_sd=0`, `audio_pwm=0`, no `done`, no further reads.
- **Request priority:**
  - `play` pulses during PLAY: required no restart and no extra reads.
  - `play` and `stop` together in IDLE: required to stay in IDLE.
  - `stop` coincident with the final terminal tick: required IDLE and no `done`.
- **Single word:** `CHUNKS=1`.
  - Required: exactly one read (addr 0) and 4 samples.
  - `done` at cycle `3 + 4*CLKS_PER_SAMPLE`.

Source files
------------

// File: rtl/pcm_playback.sv
// Voice playback: reads packed sample words from the voice RAM and replays them as PWM audio.
// Latency: first sample on the PWM path three cycles after play; audio_pwm lags sample by one cycle.
// Backpressure: none; the RAM read port is owned here and is read at a fixed cadence with one word of prefetch.
module pcm_playback #(
    parameter int SAMPLE_W        = 8,
    parameter int ADDR_W          = 12,
    parameter int CHUNKS          = 2830,
    parameter int CLKS_PER_SAMPLE = 300
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play,
    input  logic                  stop,
    output logic                  ram_rd_en,
    output logic [ADDR_W-1:0]     ram_rd_addr,
    input  logic [4*SAMPLE_W-1:0] ram_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  audio_pwm,
    output logic                  audio_sd
);

    localparam int WORD_W = 4 * SAMPLE_W;
    localparam int TICK_W = $clog2(CLKS_PER_SAMPLE);

    // Last tick of a sample period and index of the final word to be played.
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [ADDR_W-1:0]   LAST_IDX  = ADDR_W'(CHUNKS - 1);
    localparam logic [SAMPLE_W-1:0] MIDSCALE  = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Word being played and the prefetched word that follows it.
    logic [WORD_W-1:0]   cur_word;
    logic [WORD_W-1:0]   nxt_word;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          lane;
    logic [TICK_W-1:0]   tick;
    logic                pf_pend;
    logic [SAMPLE_W-1:0] pwm_cnt;
    logic [SAMPLE_W-1:0] sample;

    logic last_tick;
    logic word_end;
    logic last_word;
    logic pf_slot;
    logic busy_nxt;

    assign last_tick = (tick == TICK_LAST);
    assign word_end  = last_tick && (lane == 2'd3);
    assign last_word = (word_idx == LAST_IDX);

    // Prefetch slot: first tick of lane 0, only while another word remains.
    assign pf_slot   = (lane == 2'd0) && (tick == '0) && (word_idx < LAST_IDX);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign audio_sd  = busy;
    assign busy_nxt  = (state_nxt != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and RAM read strobe; stop overrides every transition outside IDLE.
    always_comb begin
        state_nxt   = state;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        case (state)
            S_IDLE: begin
                if (play && !stop) begin
                    state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = '0;
                state_nxt   = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (pf_slot) begin
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = word_idx + 1'b1;
                end
                if (word_end && last_word) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (stop && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    // Sample/word counters: cleared whenever playback ends, loaded in LOAD, advanced in PLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_word <= '0;
            word_idx <= '0;
            lane     <= '0;
            tick     <= '0;
        end else if (state_nxt == S_IDLE) begin
            word_idx <= '0;
            lane     <= '0;
            tick     <= '0;
        end else if (state == S_LOAD) begin
            cur_word <= ram_rd_data;
            word_idx <= '0;
            lane     <= '0;
            tick     <= '0;
        end else if (state == S_PLAY) begin
            if (last_tick) begin
                tick <= '0;
                lane <= lane + 2'd1;
                // Swap in the prefetched word with no gap at the word boundary.
                if (word_end && !last_word) begin
                    cur_word <= nxt_word;
                    word_idx <= word_idx + 1'b1;
                end
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    // Prefetch capture: RAM data is valid the cycle after the strobe was issued from PLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_pend  <= 1'b0;
            nxt_word <= '0;
        end else begin
            pf_pend <= ram_rd_en && (state == S_PLAY) && (state_nxt != S_IDLE);
            if (pf_pend) begin
                nxt_word <= ram_rd_data;
            end
        end
    end

    // Current sample: selected lane while playing, midscale otherwise.
    always_comb begin
        sample = MIDSCALE;
        if (state == S_PLAY) begin
            case (lane)
                2'd0:    sample = cur_word[0*SAMPLE_W +: SAMPLE_W];
                2'd1:    sample = cur_word[1*SAMPLE_W +: SAMPLE_W];
                2'd2:    sample = cur_word[2*SAMPLE_W +: SAMPLE_W];
                default: sample = cur_word[3*SAMPLE_W +: SAMPLE_W];
            endcase
        end
    end

    // Free-running PWM carrier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Registered PWM output; gated with the next busy so the output is low the cycle playback ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_pwm <= 1'b0;
        end else begin
            audio_pwm <= busy_nxt && (pwm_cnt < sample);
        end
    end

endmodule

// File: tb/tb_pcm_playback.sv
module tb_pcm_playback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance 0: three words, four clocks per sample.
    logic        play0, stop0;
    logic        ram_rd_en0;
    logic [11:0] ram_rd_addr0;
    logic [31:0] ram_rd_data0;
    logic        busy0, done0, pwm0, sd0;
    logic [31:0] mem0 [0:3];

    // Instance 1: single word, long samples for duty measurement.
    logic        play1, stop1;
    logic        ram_rd_en1;
    logic [3:0]  ram_rd_addr1;
    logic [31:0] ram_rd_data1;
    logic        busy1, done1, pwm1, sd1;
    logic [31:0] mem1;

    int total = 0;
    int bad   = 0;

    always @(posedge clk) begin
        if (ram_rd_en0) ram_rd_data0 <= mem0[ram_rd_addr0[1:0]];
        if (ram_rd_en1) ram_rd_data1 <= mem1;
    end

    pcm_playback #(.SAMPLE_W(8), .ADDR_W(12), .CHUNKS(3), .CLKS_PER_SAMPLE(4)) u0 (
        .clk(clk), .rst(rst), .play(play0), .stop(stop0),
        .ram_rd_en(ram_rd_en0), .ram_rd_addr(ram_rd_addr0), .ram_rd_data(ram_rd_data0),
        .busy(busy0), .done(done0), .audio_pwm(pwm0), .audio_sd(sd0)
    );

    pcm_playback #(.SAMPLE_W(8), .ADDR_W(4), .CHUNKS(1), .CLKS_PER_SAMPLE(1024)) u1 (
        .clk(clk), .rst(rst), .play(play1), .stop(stop1),
        .ram_rd_en(ram_rd_en1), .ram_rd_addr(ram_rd_addr1), .ram_rd_data(ram_rd_data1),
        .busy(busy1), .done(done1), .audio_pwm(pwm1), .audio_sd(sd1)
    );

    // Play instance 0 from edge 0 and compare every cycle against the playback rules:
    // word w lane l occupies cycles 3+16w+4l .. +3, reads at cycle 1 (addr 0) and 3+16(w-1) (addr w),
    // done at 51; stop at cycle s ends everything from cycle s+1.
    task automatic test_playback(input string name, input int s, input int replay_at);
        logic [31:0] w;
        logic [7:0]  es;
        logic [11:0] ea;
        bit          act, eb, ed, er;
        int          p;
        @(negedge clk);
        play0 = 1'b1;
        stop0 = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            act = (s < 0) || (k <= s);
            eb  = act && (k <= 51);
            ed  = act && (k == 51);
            es  = 8'h80;
            if (act && k >= 3 && k < 51) begin
                p  = k - 3;
                w  = mem0[p / 16];
                es = w[8 * ((p / 4) % 4) +: 8];
            end
            er = act && ((k == 1) || (k >= 3 && k < 51 && (k - 3) % 16 == 0 && (k - 3) / 16 < 2));
            ea = (k == 1) ? 12'd0 : 12'((k - 3) / 16 + 1);

            total++;
            if (u0.sample !== es) begin
                bad++;
                $display("FAIL %s sample cyc=%0d got=%h exp=%h", name, k, u0.sample, es);
            end
            total++;
            if (busy0 !== eb) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, k, busy0, eb);
            end
            total++;
            if (sd0 !== eb) begin
                bad++;
                $display("FAIL %s audio_sd cyc=%0d got=%b exp=%b", name, k, sd0, eb);
            end
            total++;
            if (done0 !== ed) begin
                bad++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, k, done0, ed);
            end
            total++;
            if (ram_rd_en0 !== er) begin
                bad++;
                $display("FAIL %s rd_en cyc=%0d got=%b exp=%b addr=%0d", name, k, ram_rd_en0, er, ram_rd_addr0);
            end
            if (er) begin
                total++;
                if (ram_rd_addr0 !== ea) begin
                    bad++;
                    $display("FAIL %s rd_addr cyc=%0d got=%0d exp=%0d", name, k, ram_rd_addr0, ea);
                end
            end
            if (!eb) begin
                total++;
                if (pwm0 !== 1'b0) begin
                    bad++;
                    $display("FAIL %s pwm_idle cyc=%0d got=%b exp=0", name, k, pwm0);
                end
            end
            play0 = (k == replay_at);
            stop0 = (k == s);
        end
        play0 = 1'b0;
        stop0 = 1'b0;
    endtask

    task automatic test_reset_values;
        total++;
        if ({busy0, done0, ram_rd_en0, pwm0, sd0} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000", {busy0, done0, ram_rd_en0, pwm0, sd0});
        end
        total++;
        if (ram_rd_addr0 !== 12'd0) begin
            bad++;
            $display("FAIL reset_addr got=%0d exp=0", ram_rd_addr0);
        end
        total++;
        if (u0.sample !== 8'h80) begin
            bad++;
            $display("FAIL reset_sample got=%h exp=80", u0.sample);
        end
        total++;
        if (u0.pwm_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset_pwm_cnt got=%h exp=00", u0.pwm_cnt);
        end
        total++;
        if ({busy1, done1, ram_rd_en1, pwm1, sd1} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs_u1 got=%b exp=00000", {busy1, done1, ram_rd_en1, pwm1, sd1});
        end
    endtask

    task automatic test_normal;
        mem0[0] = 32'h04030201;
        mem0[1] = 32'h08070605;
        mem0[2] = 32'h0C0B0A09;
        mem0[3] = 32'hDEADBEEF;
        test_playback("normal", -1, -1);
    endtask

    // Asynchronous reset mid-PLAY, while the prefetch strobe is up.
    task automatic test_reset;
        @(negedge clk);
        play0 = 1'b1;
        @(negedge clk);
        play0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ram_rd_en0 !== 1'b1 || ram_rd_addr0 !== 12'd1) begin
            bad++;
            $display("FAIL rst_pre_read got=%b/%0d exp=1/1", ram_rd_en0, ram_rd_addr0);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy0, done0, ram_rd_en0, pwm0, sd0} !== 5'b0) begin
            bad++;
            $display("FAIL rst_async_outputs got=%b exp=00000", {busy0, done0, ram_rd_en0, pwm0, sd0});
        end
        total++;
        if (ram_rd_addr0 !== 12'd0) begin
            bad++;
            $display("FAIL rst_async_addr got=%0d exp=0", ram_rd_addr0);
        end
        total++;
        if (u0.sample !== 8'h80) begin
            bad++;
            $display("FAIL rst_async_sample got=%h exp=80", u0.sample);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (done0 !== 1'b0 || busy0 !== 1'b0) begin
                bad++;
                $display("FAIL rst_after cyc=%0d done=%b busy=%b exp=0/0", k, done0, busy0);
            end
        end
        test_playback("restart", -1, -1);
    endtask

    task automatic test_random;
        int s;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 3; j++) mem0[j] = $urandom;
            s = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 52));
            test_playback($sformatf("random%0d_s%0d", i, s), s, -1);
        end
    endtask

    task automatic test_stop_mid_word;
        for (int j = 0; j < 3; j++) mem0[j] = $urandom;
        test_playback("stop_mid_word", 28, -1);
    endtask

    task automatic test_priority;
        test_playback("replay_play", -1, 10);
        test_playback("replay_late", -1, 40);
        test_playback("stop_final_tick", 50, -1);
        test_playback("stop_in_done", 51, -1);
        // play and stop together in IDLE
        @(negedge clk);
        play0 = 1'b1;
        stop0 = 1'b1;
        @(negedge clk);
        play0 = 1'b0;
        stop0 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            total++;
            if (busy0 !== 1'b0 || ram_rd_en0 !== 1'b0) begin
                bad++;
                $display("FAIL idle_play_stop cyc=%0d busy=%b rd_en=%b exp=0/0", k, busy0, ram_rd_en0);
            end
            @(negedge clk);
        end
    endtask

    // One word of four 1024-cycle samples: 0x80, 0x40, 0xC0, 0x00 (lane 0 first).
    task automatic test_single_word;
        int reads, dones, done_at, hi_a, hi_b, hi_c, hi_d;
        reads = 0; dones = 0; done_at = -1;
        hi_a = 0; hi_b = 0; hi_c = 0; hi_d = 0;
        mem1 = 32'h00C04080;
        @(negedge clk);
        play1 = 1'b1;
        for (int k = 1; k <= 4105; k++) begin
            @(negedge clk);
            play1 = 1'b0;
            if (ram_rd_en1) begin
                reads++;
                total++;
                if (k != 1 || ram_rd_addr1 !== 4'd0) begin
                    bad++;
                    $display("FAIL single_read cyc=%0d addr=%0d exp cyc=1 addr=0", k, ram_rd_addr1);
                end
            end
            if (done1) begin
                dones++;
                done_at = k;
            end
            if (k >= 100  && k < 356  && pwm1) hi_a++;
            if (k >= 1100 && k < 1356 && pwm1) hi_b++;
            if (k >= 2200 && k < 2456 && pwm1) hi_c++;
            if (k >= 3076 && k < 4100 && pwm1) hi_d++;
            if (k == 515 || k == 1539 || k == 2563 || k == 3587) begin
                logic [7:0] es;
                es = (k == 515) ? 8'h80 : (k == 1539) ? 8'h40 : (k == 2563) ? 8'hC0 : 8'h00;
                total++;
                if (u1.sample !== es) begin
                    bad++;
                    $display("FAIL single_sample cyc=%0d got=%h exp=%h", k, u1.sample, es);
                end
            end
            if (k == 4100) begin
                total++;
                if (busy1 !== 1'b0 || sd1 !== 1'b0) begin
                    bad++;
                    $display("FAIL single_after_done busy=%b sd=%b exp=0/0", busy1, sd1);
                end
            end
        end
        total++;
        if (reads != 1) begin
            bad++;
            $display("FAIL single_read_count got=%0d exp=1", reads);
        end
        total++;
        if (dones != 1 || done_at != 4099) begin
            bad++;
            $display("FAIL single_done count=%0d cyc=%0d exp=1 at 4099", dones, done_at);
        end
        total++;
        if (hi_a != 128) begin
            bad++;
            $display("FAIL duty_80 got=%0d exp=128", hi_a);
        end
        total++;
        if (hi_b != 64) begin
            bad++;
            $display("FAIL duty_40 got=%0d exp=64", hi_b);
        end
        total++;
        if (hi_c != 192) begin
            bad++;
            $display("FAIL duty_C0 got=%0d exp=192", hi_c);
        end
        total++;
        if (hi_d != 0) begin
            bad++;
            $display("FAIL duty_00 got=%0d exp=0", hi_d);
        end
    endtask

    initial begin
        rst   = 1'b1;
        play0 = 1'b0;
        stop0 = 1'b0;
        play1 = 1'b0;
        stop1 = 1'b0;
        mem1  = 32'h0;
        for (int j = 0; j < 4; j++) mem0[j] = 32'h0;
        #2;
        test_reset_values();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_normal();
        test_reset();
        test_random();
        test_stop_mid_word();
        test_priority();
        test_single_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
